// File: rtl/frame_wr_pkg.sv
// Shared definitions for the camera-side SDRAM frame write sequencer.
package frame_wr_pkg;

  // Sequencer states, also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // SDRAM address layout: {1'b0, bank, row[12:0], column[8:0]}.
  localparam int ROW_LSB  = 9;
  localparam int BANK_BIT = 22;

  // Default geometry: one full 512-word page per burst, 750 rows per frame.
  localparam int DEF_BURST_LEN      = 512;
  localparam int DEF_ROWS_PER_FRAME = 750;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// An input rise becomes a one-cycle o_rise pulse three clocks later.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_rise;

  // Synchronize the raw level, then register the 0->1 transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_rise   <= r_sync & ~r_sync_d;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/sdram_frame_wr.sv
// Camera-side SDRAM write sequencer: one full-page burst request per
// BURST_LEN buffered words, row walk through a frame, bank ping-pong per frame.
//
// Handshake: wr_sdram_req rises when a burst is wanted and stays high until
// sdram_top returns a single-cycle wr_sdram_ack; the request drops on the edge
// after the ack. wr_sdram_add is stable for as long as wr_sdram_req is high.
// An ack seen while no request is outstanding is ignored.
module sdram_frame_wr
  import frame_wr_pkg::*;
#(
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int ROWS_PER_FRAME = DEF_ROWS_PER_FRAME,
  parameter int ROW_W          = 13
) (
  input  logic             clk_133M_i,
  input  logic             rst_133i,
  input  logic             cam_en_i,
  input  logic             cmos_vsyn_i,
  input  logic [10:0]      fifo_used_i,
  input  logic             wr_sdram_ack,
  output logic             wr_sdram_req,
  output logic [23:0]      wr_sdram_add,
  output logic             rd_bank_o,
  output logic             frame_valid_o,
  output logic             frame_done_o,
  output logic             frame_short_o,
  output logic [ROW_W-1:0] row_o,
  output logic [1:0]       dbg_state_o
);

  localparam logic [10:0]      L_BURST = 11'(BURST_LEN);
  localparam logic [ROW_W-1:0] L_ROWS  = ROW_W'(ROWS_PER_FRAME);

  logic [1:0]       r_rst_pipe;
  logic             w_rst;
  logic             r_cam_meta;
  logic             r_cam_en;
  logic             w_vs_rise;
  logic             w_burst_ready;
  logic [ROW_W-1:0] w_row_inc;
  logic [23:0]      w_addr;

  state_t           r_state;
  logic [ROW_W-1:0] r_row;
  logic             r_bank;
  logic             r_rd_bank;
  logic             r_valid;
  logic             r_done;
  logic             r_short;
  logic             r_req;
  logic             r_restart;

  // Reset asserts immediately and releases on the clock, two edges later.
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) r_rst_pipe <= 2'b11;
    else          r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end

  assign w_rst = r_rst_pipe[1];

  // Bring the camera-enable level into the SDRAM clock domain.
  always_ff @(posedge clk_133M_i or posedge w_rst) begin
    if (w_rst) begin
      r_cam_meta <= 1'b0;
      r_cam_en   <= 1'b0;
    end else begin
      r_cam_meta <= cam_en_i;
      r_cam_en   <= r_cam_meta;
    end
  end

  sync_edge u_vs_sync (
    .i_clk   (clk_133M_i),
    .i_rst   (w_rst),
    .i_async (cmos_vsyn_i),
    .o_rise  (w_vs_rise)
  );

  assign w_burst_ready = (fifo_used_i >= L_BURST);
  // The row count never runs past the frame end into the next frame's rows.
  assign w_row_inc     = (r_row >= L_ROWS) ? r_row : r_row + ROW_W'(1);

  // Frame sequencer: request bursts, walk rows, complete or restart frames.
  always_ff @(posedge clk_133M_i or posedge w_rst) begin
    if (w_rst) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_bank    <= 1'b0;
      r_rd_bank <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_short   <= 1'b0;
      r_req     <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_short <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_row     <= '0;
          r_req     <= 1'b0;
          r_restart <= 1'b0;
          if (r_cam_en && w_vs_rise) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!r_cam_en) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
          end else if (w_vs_rise) begin
            // Early VSYNC: overwrite the partial frame in the same bank.
            r_short <= 1'b1;
            r_row   <= '0;
          end else if (w_burst_ready) begin
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A burst in flight is never aborted; remember the VSYNC instead.
          if (w_vs_rise) r_restart <= 1'b1;
          if (wr_sdram_ack) begin
            r_req     <= 1'b0;
            r_restart <= 1'b0;
            if (r_restart) begin
              r_row   <= '0;
              r_short <= 1'b1;
              r_state <= r_cam_en ? ST_WAIT : ST_IDLE;
            end else if (w_row_inc == L_ROWS) begin
              r_done    <= 1'b1;
              r_rd_bank <= r_bank;
              r_bank    <= ~r_bank;
              r_valid   <= 1'b1;
              if (w_vs_rise) begin
                // VSYNC on the final ack starts the next frame directly.
                r_row   <= '0;
                r_state <= r_cam_en ? ST_WAIT : ST_IDLE;
              end else begin
                r_row   <= w_row_inc;
                r_state <= ST_DONE;
              end
            end else if (w_vs_rise) begin
              r_row   <= '0;
              r_short <= 1'b1;
              r_state <= r_cam_en ? ST_WAIT : ST_IDLE;
            end else begin
              r_row   <= r_cam_en ? w_row_inc : '0;
              r_state <= r_cam_en ? ST_WAIT : ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          if (!r_cam_en) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
          end else if (w_vs_rise) begin
            r_row   <= '0;
            r_state <= ST_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Address is a straight concatenation of registered bank and row.
  always_comb begin
    w_addr = '0;
    w_addr[BANK_BIT] = r_bank;
    w_addr[ROW_LSB +: ROW_W] = r_row;
  end

  assign wr_sdram_req  = r_req;
  assign wr_sdram_add  = w_addr;
  assign rd_bank_o     = r_rd_bank;
  assign frame_valid_o = r_valid;
  assign frame_done_o  = r_done;
  assign frame_short_o = r_short;
  assign row_o         = r_row;
  assign dbg_state_o   = r_state;

endmodule

// File: doc/sdram_frame_wr.md
# sdram_frame_wr

Camera-side SDRAM write sequencer. Sits between `cam2fifo` (source of `fifo_used` and burst data) and `sdram_top` (write port). It issues one full-page burst write request per 512 pixels buffered, walks the row address through a frame, and ping-pongs frames between two SDRAM banks. It tells the display side which bank holds the last complete frame.

## Interface
Parameters:
- `BURST_LEN`, 512: words per write burst; also the FIFO fill level that triggers a request.
- `ROWS_PER_FRAME`, 750: bursts (SDRAM rows) per complete frame.
- `ROW_W`, 13: row-counter width; maps to `wr_sdram_add[21:9]`.

Ports:
- `clk_133M_i`  in  1  SDRAM-domain clock.
- `rst_133i`  in  1  asynchronous, active-high reset.
- `cam_en_i`  in  1  camera configured and stable; asynchronous level, synchronized internally.
- `cmos_vsyn_i`  in  1  raw camera VSYNC; asynchronous, synchronized internally.
- `fifo_used_i`  in  11  cam2fifo read-side word count; synchronous to `clk_133M_i`.
- `wr_sdram_ack`  in  1  one-cycle pulse from `sdram_top` when the burst completes.
- `wr_sdram_req`  out  1  burst write request; held until ack.
- `wr_sdram_add`  out  24  `{1'b0, bank, row[12:0], 9'b0}`.
- `rd_bank_o`  out  1  bank holding the most recent complete frame.
- `frame_valid_o`  out  1  set after the first complete frame; sticky until reset.
- `frame_done_o`  out  1  one-cycle pulse when a frame completes.
- `frame_short_o`  out  1  one-cycle pulse when VSYNC arrives before `ROWS_PER_FRAME` rows are written.
- `row_o`  out  13  current row count, for the digitron and debug.

## Operation
- Synchronization: `cam_en_i` and `cmos_vsyn_i` pass through 2-FF synchronizers. `vs_rise` is the rising edge of synced VSYNC, registered.
- States:
  - IDLE: waits for `cam_en` and `vs_rise`, then goes to WAIT; row=0.
  - WAIT: if `fifo_used_i >= BURST_LEN`, goes to REQ and sets req=1.
  - REQ: req held high. On ack, req=0, row+1, then goes to DONE if row+1 == `ROWS_PER_FRAME`, else to WAIT.
  - DONE: on entry, `frame_done_o` pulses, `rd_bank_o`<=bank, bank<=~bank, `frame_valid_o`<=1. Waits for `vs_rise`, then row=0 and goes to WAIT.
- VSYNC in WAIT (short frame): `frame_short_o` pulses, row=0, bank unchanged (the partial frame is overwritten), stays in WAIT.
- VSYNC in REQ: the burst is never aborted. A pending-restart flag is latched. On ack, the ack's row increment is discarded, row=0, `frame_short_o` pulses, and the state goes to WAIT.
- VSYNC together with the final ack: the frame completes normally (DONE actions run), and the VSYNC is consumed as the next frame start. Row=0, state goes to WAIT.
- `cam_en` deasserted in any state except REQ: go to IDLE, row=0, bank and `rd_bank_o` held. In REQ, finish the burst first, then go to IDLE.
- Ack outside REQ is ignored.
- Row counter saturates at `ROWS_PER_FRAME`. It never wraps into the next frame's region.

## Timing
- Reset values: all outputs 0, state IDLE, bank 0, synchronizers 0, restart flag 0.
- `cmos_vsyn_i` rise to `vs_rise` visible to the FSM: 3 clocks.
- Req latency: req goes high 1 clock after `fifo_used_i` crosses threshold in WAIT.
- Ack to req low: req drops 1 clock after ack is sampled. Row and address update on the same edge.
- Minimum 1 clock of req low between bursts; the next request is decided in WAIT with the updated `fifo_used_i`.
- `wr_sdram_add` is registered from bank and row. It is stable for the whole time req is high.
- Reset is asynchronous assert and synchronous deassert. Reset mid-burst drops req immediately; `sdram_top` is reset from the same source.

## Structure
- Package `frame_wr_pkg` holds:
  - the state encoding (IDLE, WAIT, REQ, DONE);
  - `ROW_LSB`=9 and `BANK_BIT`=22;
  - the default `BURST_LEN` and `ROWS_PER_FRAME`.
- Sub-module `sync_edge`: 2-FF synchronizer plus registered rising-edge output. Instantiated for VSYNC; the level output alone is used for `cam_en`.

## Test plan
- Full frame: cam_en=1, one VSYNC, `fifo_used_i`=512 held, ack 20 clocks after each req. Expect 750 reqs with `wr_sdram_add[21:9]` = 0..749 and bit22=0, then one `frame_done_o` pulse, `rd_bank_o`=0, `frame_valid_o`=1, next frame bit22=1.
- Threshold: `fifo_used_i`=511 gives no req for 1000 clocks. Stepping to 512 gives req 1 clock later.
- Short frame: VSYNC after 300 acks in WAIT gives a `frame_short_o` pulse, next address row 0 with bank unchanged, and `frame_valid_o` stays 0.
- VSYNC during REQ at row 100: req stays high until ack. After ack, `frame_short_o` pulses and the next req uses row 0.
- VSYNC on the same cycle as the 750th ack: `frame_done_o` pulses, bank toggles, and the next req is at row 0 of the new bank with no IDLE detour.
- Reset asserted mid-burst at row 42: req=0 asynchronously and all outputs are 0. After release, nothing happens until cam_en and VSYNC.
